bounce_gen: RTL

BOUNCE_GEN -- requirements
Module: bounce_gen

---
 rtl/bounce_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bounce_gen.sv
// Emulates a bouncing mechanical switch for debouncer stimulus.
// Build macro BOUNCE_GEN_RANDOM_EN selects LFSR-randomised gaps; without it every gap is 2**GAP_W cycles.
module bounce_gen #(
    parameter int          N_BOUNCE  = 3,
    parameter int          GAP_W     = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean_in,
    output logic sig_out,
    output logic busy,
    output logic settled
);

    typedef enum logic {
        IDLE,
        BOUNCE
    } state_t;

    localparam logic [4:0] REM_INIT = 5'(2 * N_BOUNCE);

    state_t           state_q, state_d;
    logic             sig_out_q, sig_out_d;
    logic             busy_q, busy_d;
    logic             settled_q, settled_d;
    logic [4:0]       remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_load;

`ifdef BOUNCE_GEN_RANDOM_EN
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gap_load = lfsr_q[GAP_W-1:0];
`else
    assign gap_load = '1;
`endif

    always_comb begin
        state_d     = state_q;
        sig_out_d   = sig_out_q;
        busy_d      = busy_q;
        settled_d   = 1'b0;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (clean_in != sig_out_q) begin
                    sig_out_d   = ~sig_out_q;
                    remaining_d = REM_INIT;
                    gap_cnt_d   = gap_load;
                    if (N_BOUNCE > 0) begin
                        state_d = BOUNCE;
                        busy_d  = 1'b1;
                    end else begin
                        settled_d = 1'b1;
                    end
                end
            end
            BOUNCE: begin
                if (remaining_q == 5'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (gap_cnt_q == '0) begin
                    sig_out_d   = ~sig_out_q;
                    remaining_d = remaining_q - 5'd1;
                    gap_cnt_d   = gap_load;
                    if (remaining_q == 5'd1) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        settled_d = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sig_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            settled_q   <= 1'b0;
            remaining_q <= 5'd0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sig_out_q   <= sig_out_d;
            busy_q      <= busy_d;
            settled_q   <= settled_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign sig_out = sig_out_q;
    assign busy    = busy_q;
    assign settled = settled_q;

endmodule
